// File: rtl/countdown_timer_if.sv
// countdown_timer_if
// Groups the control and status signals of countdown_timer into one bundle.
// The clock (counter_clock) and reset (rst) stay plain ports on the module.
//
//   master : drives switch, load, load_value, auto_reload; observes status
//   slave  : the timer itself; observes controls, drives status
//
// Signals
//   switch       run enable level (1 = count, 0 = pause)
//   load         single-cycle load strobe
//   load_value   value captured on load, also kept as the reload value
//   auto_reload  1 = restart from the reload value on expiry
//   counter      current count (registered)
//   zero         counter == 0
//   done_pulse   one-cycle pulse on entering DONE
//   running      timer is in the RUN state
//
// WIDTH must match the WIDTH parameter of the countdown_timer it connects to.
interface countdown_timer_if #(
    parameter int WIDTH = 4
);
    logic             switch;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             auto_reload;
    logic [WIDTH-1:0] counter;
    logic             zero;
    logic             done_pulse;
    logic             running;

    modport master (
        output switch, load, load_value, auto_reload,
        input  counter, zero, done_pulse, running
    );

    modport slave (
        input  switch, load, load_value, auto_reload,
        output counter, zero, done_pulse, running
    );
endinterface

// File: rtl/countdown_timer.sv
// countdown_timer
// Loadable down-counter with a prescaler, run/pause control, terminal-count
// detection and optional auto-reload. Counts from the loaded value toward
// zero, one step every PRESCALE cycles while running, and pulses done_pulse
// for one cycle when it reaches zero.
//
// Ports
//   counter_clock  single clock, all logic on its rising edge
//   rst            synchronous reset, active-low
//   bus            countdown_timer_if.slave (switch, load, load_value,
//                  auto_reload in; counter, zero, done_pulse, running out)
//
// Parameters
//   WIDTH            counter width in bits
//   PRESCALE         clock cycles per decrement tick (>= 1)
//   DEBOUNCE_CYCLES  stable-cycle count of the switch filter
//
// Build option
//   COUNTDOWN_DEBOUNCE_EN  when defined, switch goes through a 2-FF
//   synchronizer and a stability filter before reaching the state logic
//   (2 + DEBOUNCE_CYCLES cycles of run/pause latency). When undefined,
//   switch is used directly and DEBOUNCE_CYCLES has no effect.
module countdown_timer #(
    parameter int WIDTH           = 4,
    parameter int PRESCALE        = 1,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                counter_clock,
    input  logic                rst,
    countdown_timer_if.slave    bus
);

    // One spare bit so the terminal comparison never overflows, even for
    // PRESCALE equal to a power of two.
    localparam int               PS_W    = $clog2(PRESCALE) + 1;
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [PS_W-1:0]  PS_ONE  = PS_W'(1);
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] counter_reg, counter_next;
    logic [WIDTH-1:0] reload_reg, reload_next;
    logic [PS_W-1:0]  prescaler_reg, prescaler_next;
    logic             done_pulse_reg, done_pulse_next;
    logic             running_comb;
    logic             switch_eff;

    // Elaboration-time guard: both periods must be at least one cycle.
    // An illegal value leaves this block in place as a marker in the
    // elaborated hierarchy; legal values elaborate nothing.
    if (PRESCALE < 1 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
    end

`ifdef COUNTDOWN_DEBOUNCE_EN
    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      sync_reg;
    logic            switch_filt_reg;
    logic [DB_W-1:0] stable_cnt_reg;

    // The filtered level follows the synchronized switch only once the
    // synchronized value has disagreed with it for DEBOUNCE_CYCLES cycles
    // in a row; any return to agreement restarts the count.
    always_ff @(posedge counter_clock) begin
        if (!rst) begin
            sync_reg        <= 2'b00;
            switch_filt_reg <= 1'b0;
            stable_cnt_reg  <= '0;
        end else begin
            sync_reg <= {sync_reg[0], bus.switch};
            if (sync_reg[1] == switch_filt_reg) begin
                stable_cnt_reg <= '0;
            end else if (stable_cnt_reg == DB_LAST) begin
                switch_filt_reg <= sync_reg[1];
                stable_cnt_reg  <= '0;
            end else begin
                stable_cnt_reg <= stable_cnt_reg + DB_W'(1);
            end
        end
    end

    assign switch_eff = switch_filt_reg;
`else
    assign switch_eff = bus.switch;
`endif

    // State and datapath registers.
    always_ff @(posedge counter_clock) begin
        if (!rst) begin
            state_reg      <= IDLE;
            counter_reg    <= '1;
            reload_reg     <= '1;
            prescaler_reg  <= '0;
            done_pulse_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            counter_reg    <= counter_next;
            reload_reg     <= reload_next;
            prescaler_reg  <= prescaler_next;
            done_pulse_reg <= done_pulse_next;
        end
    end

    // Next-state and datapath logic. A load takes precedence over anything
    // the current state would do, including a tick on the same edge.
    always_comb begin
        state_next      = state_reg;
        counter_next    = counter_reg;
        reload_next     = reload_reg;
        prescaler_next  = prescaler_reg;
        done_pulse_next = 1'b0;

        if (bus.load) begin
            counter_next   = bus.load_value;
            reload_next    = bus.load_value;
            prescaler_next = '0;
            if (bus.load_value == '0) begin
                // Loading zero expires immediately.
                state_next      = DONE;
                done_pulse_next = 1'b1;
            end else begin
                state_next = switch_eff ? RUN : PAUSE;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (switch_eff) state_next = RUN;
                end
                RUN: begin
                    if (!switch_eff) begin
                        // Pausing freezes the prescaler phase as well.
                        state_next = PAUSE;
                    end else if (prescaler_reg == PS_LAST) begin
                        prescaler_next = '0;
                        // Saturate at zero: a zero count never wraps.
                        if (counter_reg != '0) counter_next = counter_reg - CNT_ONE;
                        if (counter_reg == CNT_ONE) begin
                            state_next      = DONE;
                            done_pulse_next = 1'b1;
                        end
                    end else begin
                        prescaler_next = prescaler_reg + PS_ONE;
                    end
                end
                PAUSE: begin
                    if (switch_eff) state_next = RUN;
                end
                DONE: begin
                    // Without auto-reload DONE is sticky; switch is ignored.
                    if (bus.auto_reload) begin
                        counter_next   = reload_reg;
                        prescaler_next = '0;
                        state_next     = RUN;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Output decode.
    always_comb begin
        running_comb = (state_reg == RUN);
    end

    assign bus.counter    = counter_reg;
    assign bus.zero       = (counter_reg == '0);
    assign bus.done_pulse = done_pulse_reg;
    assign bus.running    = running_comb;

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer
// Drives two timers (PRESCALE=1 and PRESCALE=4) from the same stimulus and
// compares every output, every cycle, against a behavioural model. The model
// describes a run as "loaded value minus completed ticks", where completed
// ticks = (cycles spent counting since the last load/reload) / PRESCALE.
// Directed scenarios add explicit expected constants at the notable points.
module tb_countdown_timer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_v;
    logic         sw_v;
    logic         load_v;
    logic [W-1:0] lv_v;
    logic         ar_v;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    countdown_timer_if #(.WIDTH(W)) bus_p1 ();
    countdown_timer_if #(.WIDTH(W)) bus_p4 ();

    assign bus_p1.switch      = sw_v;
    assign bus_p1.load        = load_v;
    assign bus_p1.load_value  = lv_v;
    assign bus_p1.auto_reload = ar_v;
    assign bus_p4.switch      = sw_v;
    assign bus_p4.load        = load_v;
    assign bus_p4.load_value  = lv_v;
    assign bus_p4.auto_reload = ar_v;

    countdown_timer #(.WIDTH(W), .PRESCALE(1), .DEBOUNCE_CYCLES(4)) u_p1 (
        .counter_clock (clk),
        .rst           (rst_v),
        .bus           (bus_p1)
    );

    countdown_timer #(.WIDTH(W), .PRESCALE(4), .DEBOUNCE_CYCLES(4)) u_p4 (
        .counter_clock (clk),
        .rst           (rst_v),
        .bus           (bus_p4)
    );

    // Behavioural model, one entry per timer instance.
    int psc     [2] = '{1, 4};
    int m_base  [2];   // value the current run started from
    int m_reload[2];   // value restored on auto-reload
    int m_act   [2];   // counting cycles since the run started
    bit m_exp   [2];   // expired (sitting at zero in DONE)
    bit m_run   [2];   // actively counting
    bit m_pulse [2];

    function automatic int exp_count(input int i);
        return m_exp[i] ? 0 : (m_base[i] - m_act[i] / psc[i]);
    endfunction

    task automatic model_edge(input int i);
        if (!rst_v) begin
            m_base[i] = 15; m_reload[i] = 15; m_act[i] = 0;
            m_exp[i] = 0; m_run[i] = 0; m_pulse[i] = 0;
        end else if (load_v) begin
            m_base[i]   = int'(lv_v);
            m_reload[i] = int'(lv_v);
            m_act[i]    = 0;
            m_exp[i]    = (lv_v == 0);
            m_pulse[i]  = (lv_v == 0);
            m_run[i]    = sw_v && (lv_v != 0);
        end else if (m_exp[i]) begin
            m_pulse[i] = 0;
            if (ar_v) begin
                m_base[i] = m_reload[i]; m_act[i] = 0;
                m_exp[i] = 0; m_run[i] = 1;
            end
        end else begin
            m_pulse[i] = 0;
            if (m_run[i]) begin
                if (sw_v) begin
                    m_act[i]++;
                    if (m_base[i] - m_act[i] / psc[i] == 0) begin
                        m_exp[i] = 1; m_pulse[i] = 1; m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = sw_v;   // idle or paused: resume on switch
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_model();
        chk("p1.counter", 32'(bus_p1.counter), 32'(exp_count(0)));
        chk("p1.zero", 32'(bus_p1.zero), 32'(exp_count(0) == 0));
        chk("p1.done_pulse", 32'(bus_p1.done_pulse), 32'(m_pulse[0]));
        chk("p1.running", 32'(bus_p1.running), 32'(m_run[0]));
        chk("p4.counter", 32'(bus_p4.counter), 32'(exp_count(1)));
        chk("p4.zero", 32'(bus_p4.zero), 32'(exp_count(1) == 0));
        chk("p4.done_pulse", 32'(bus_p4.done_pulse), 32'(m_pulse[1]));
        chk("p4.running", 32'(bus_p4.running), 32'(m_run[1]));
    endtask

    // One clock edge with the given inputs, then model update and compare.
    task automatic step(input logic r, input logic s, input logic l,
                        input logic [W-1:0] v, input logic a);
        rst_v = r; sw_v = s; load_v = l; lv_v = v; ar_v = a;
        @(posedge clk);
        #1;
        model_edge(0);
        model_edge(1);
        check_model();
        $display("t=%0t rst=%0b sw=%0b load=%0b lv=%0d ar=%0b | p1 cnt=%0d dp=%0b run=%0b | p4 cnt=%0d dp=%0b run=%0b",
                 $time, r, s, l, v, a, bus_p1.counter, bus_p1.done_pulse, bus_p1.running,
                 bus_p4.counter, bus_p4.done_pulse, bus_p4.running);
    endtask

    initial begin
        rst_v = 1'b0; sw_v = 1'b0; load_v = 1'b0; lv_v = '0; ar_v = 1'b0;

        // 1. Reset with random inputs: reset overrides load/switch.
        for (int k = 0; k < 2; k++)
            step(1'b0, 1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom));
        chk("reset counter", 32'(bus_p1.counter), 32'd15);
        chk("reset zero", 32'(bus_p1.zero), 32'd0);
        chk("reset done_pulse", 32'(bus_p1.done_pulse), 32'd0);
        chk("reset running", 32'(bus_p1.running), 32'd0);
        step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);          // IDLE -> RUN
        chk("enter run counter", 32'(bus_p1.counter), 32'd15);
        step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("first decrement", 32'(bus_p1.counter), 32'd14);

        // 2. Load 3, count down to zero, stay there.
        step(1'b1, 1'b1, 1'b1, 4'd3, 1'b0);
        chk("load3 counter", 32'(bus_p1.counter), 32'd3);
        for (int k = 1; k <= 3; k++) begin
            step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
            chk("countdown", 32'(bus_p1.counter), 32'(3 - k));
            chk("countdown pulse", 32'(bus_p1.done_pulse), 32'(k == 3));
        end
        for (int k = 0; k < 12; k++) step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("done hold counter", 32'(bus_p1.counter), 32'd0);
        chk("done hold pulse", 32'(bus_p1.done_pulse), 32'd0);

        // 3. Pause with PRESCALE=4, resuming mid-phase.
        step(1'b1, 1'b1, 1'b1, 4'd9, 1'b0);
        for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("p4 after 8", 32'(bus_p4.counter), 32'd7);
        for (int k = 0; k < 2; k++) step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("p4 paused counter", 32'(bus_p4.counter), 32'd7);
        chk("p4 paused running", 32'(bus_p4.running), 32'd0);
        step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);          // PAUSE -> RUN
        step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("p4 resume phase", 32'(bus_p4.counter), 32'd7);
        step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("p4 resume tick", 32'(bus_p4.counter), 32'd6);

        // 4. Auto-reload from 2: 2,1,0,2,1,0,...
        step(1'b1, 1'b1, 1'b1, 4'd2, 1'b1);
        for (int k = 1; k <= 9; k++) begin
            step(1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
            chk("reload counter", 32'(bus_p1.counter), 32'(2 - k % 3));
            chk("reload pulse", 32'(bus_p1.done_pulse), 32'(k % 3 == 2));
        end

        // 5. Load on a tick edge, then load of zero.
        step(1'b1, 1'b1, 1'b1, 4'd9, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("pre-collision", 32'(bus_p1.counter), 32'd6);
        step(1'b1, 1'b1, 1'b1, 4'd5, 1'b0);
        chk("collision load wins", 32'(bus_p1.counter), 32'd5);
        step(1'b1, 1'b1, 1'b1, 4'd0, 1'b0);
        chk("load0 pulse", 32'(bus_p1.done_pulse), 32'd1);
        chk("load0 zero", 32'(bus_p1.zero), 32'd1);
        chk("load0 running", 32'(bus_p1.running), 32'd0);
        step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("load0 pulse width", 32'(bus_p1.done_pulse), 32'd0);

        // 6. Reset mid-run restores 15 as both count and reload value.
        step(1'b1, 1'b1, 1'b1, 4'd9, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("pre-reset", 32'(bus_p1.counter), 32'd4);
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        chk("mid reset counter", 32'(bus_p1.counter), 32'd15);
        chk("mid reset running", 32'(bus_p1.running), 32'd0);
        for (int k = 0; k < 16; k++) step(1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
        chk("rundown pulse", 32'(bus_p1.done_pulse), 32'd1);
        step(1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
        chk("reload after reset", 32'(bus_p1.counter), 32'd15);
        chk("reload running", 32'(bus_p1.running), 32'd1);

        // Randomized traffic, model-checked every cycle.
        for (int k = 0; k < 400; k++) begin
            logic         r, s, l, a;
            logic [W-1:0] v;
            r = ($urandom_range(49, 0) != 0);
            s = ($urandom_range(3, 0) != 0);
            l = ($urandom_range(7, 0) == 0);
            v = 4'($urandom_range(15, 1));
            a = 1'($urandom);
            step(r, s, l, v, a);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
